// File: rtl/mm_result_drain_if.sv
// Handshake bundle between the compute slices, the result drain and the 8-bit output path.
// master = tile producer / byte consumer side, slave = the drain itself.
interface mm_result_drain_if #(
    parameter int unsigned COMPUTE_SLICES = 4,
    parameter int unsigned ACC_WIDTH      = 16
);
    logic [COMPUTE_SLICES*COMPUTE_SLICES*ACC_WIDTH-1:0] acc_in;
    logic                                               acc_valid;
    logic                                               acc_ready;
    logic                                               mode_sat;
    logic [3:0]                                         shift;
    logic [7:0]                                         out_data;
    logic                                               out_valid;
    logic                                               out_ready;
    logic                                               out_last;
    logic                                               busy;

    modport master (
        output acc_in, acc_valid, mode_sat, shift, out_ready,
        input  acc_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  acc_in, acc_valid, mode_sat, shift, out_ready,
        output acc_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/mm_result_drain.sv
// Result drain: shadows one N x N accumulator tile and streams it out a byte per handshake,
// with optional arithmetic shift and int8 saturation per element.
module mm_result_drain #(
    parameter int unsigned COMPUTE_SLICES = 4,
    parameter int unsigned ACC_WIDTH      = 16
) (
    input logic             clk,
    input logic             rst,
    mm_result_drain_if.slave bus
);
    localparam int unsigned ELEMS      = COMPUTE_SLICES * COMPUTE_SLICES;
    localparam int unsigned EW         = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int unsigned BYTES_FULL = ACC_WIDTH / 8;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-128);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                       state_q, state_d;
    logic [EW-1:0]                elem_q, elem_d;
    logic [1:0]                   byte_q, byte_d;
    logic [ELEMS*ACC_WIDTH-1:0]   buf_q, buf_d;
    logic                         sat_q, sat_d;
    logic [3:0]                   shift_q, shift_d;

    logic [ACC_WIDTH-1:0]         elems [ELEMS];
    logic signed [ACC_WIDTH-1:0]  elem_val;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [31:0]           shifted_ext;
    logic [7:0]                   byte_val;
    logic                         last_byte;
    logic                         last_elem;
    logic                         capture;

    for (genvar i = 0; i < ELEMS; i++) begin : g_elem
        assign elems[i] = buf_q[i*ACC_WIDTH +: ACC_WIDTH];
    end

    // Per-element datapath: shift, then either clamp to int8 or slice a byte of the full value.
    always_comb begin
        elem_val    = $signed(elems[elem_q]);
        shifted     = elem_val >>> shift_q;
        shifted_ext = 32'(shifted);
        if (sat_q) begin
            if (shifted > SAT_MAX) begin
                byte_val = 8'h7f;
            end else if (shifted < SAT_MIN) begin
                byte_val = 8'h80;
            end else begin
                byte_val = shifted[7:0];
            end
        end else begin
            byte_val = shifted_ext[{byte_q, 3'b000} +: 8];
        end
    end

    assign last_byte = (byte_q == (sat_q ? 2'd0 : 2'(BYTES_FULL - 1)));
    assign last_elem = (elem_q == EW'(ELEMS - 1));

    always_comb begin
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = 8'h00;
        bus.acc_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.acc_ready = 1'b1;
            end
            StStream: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.out_data  = byte_val;
                bus.out_last  = last_elem & last_byte;
                // Only the final byte's handshake frees the buffer, giving back-to-back tiles.
                bus.acc_ready = last_elem & last_byte & bus.out_ready;
            end
            default: ;
        endcase
    end

    assign capture = bus.acc_valid & bus.acc_ready;

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        byte_d  = byte_q;
        buf_d   = buf_q;
        sat_d   = sat_q;
        shift_d = shift_q;
        if (capture) begin
            state_d = StStream;
            elem_d  = '0;
            byte_d  = '0;
            buf_d   = bus.acc_in;
            sat_d   = bus.mode_sat;
            shift_d = bus.shift;
        end else if (state_q == StStream && bus.out_ready) begin
            if (last_byte) begin
                byte_d = '0;
                if (last_elem) begin
                    state_d = StIdle;
                    elem_d  = '0;
                end else begin
                    elem_d = elem_q + 1'b1;
                end
            end else begin
                byte_d = byte_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            elem_q  <= '0;
            byte_q  <= '0;
            buf_q   <= '0;
            sat_q   <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            byte_q  <= byte_d;
            buf_q   <= buf_d;
            sat_q   <= sat_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: tb/tb_mm_result_drain.sv
// Scoreboard bench for mm_result_drain (N=2, 16-bit accumulators): directed tiles with
// hand-computed byte streams, checked by an independent output monitor.
module tb_mm_result_drain;
    localparam int unsigned N  = 2;
    localparam int unsigned AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mm_result_drain_if #(.COMPUTE_SLICES(N), .ACC_WIDTH(AW)) bus ();

    mm_result_drain #(.COMPUTE_SLICES(N), .ACC_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [8:0] exp_q[$];   // {last, data}
    bit   stall_mode = 1'b0;

    bit       held = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_bytes(input logic [7:0] b[], input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), b[i]});
    endtask

    // Monitor: sample mid-cycle, compare each accepted byte and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (bus.out_valid) begin
            if (held) begin
                check("stall_data_stable", {24'h0, bus.out_data}, {24'h0, held_data});
                check("stall_last_stable", {31'h0, bus.out_last}, {31'h0, held_last});
            end
            if (bus.out_ready) begin
                held = 1'b0;
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'h0, bus.out_last, bus.out_data}, 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_data", {24'h0, bus.out_data}, {24'h0, e[7:0]});
                    check("out_last", {31'h0, bus.out_last}, {31'h0, e[8]});
                end
            end else begin
                held      = 1'b1;
                held_data = bus.out_data;
                held_last = bus.out_last;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    logic cap_on_last;

    task automatic send_tile(input logic [63:0] tile, input logic sat, input logic [3:0] sh);
        bit ok = 1'b0;
        bus.acc_in    = tile;
        bus.mode_sat  = sat;
        bus.shift     = sh;
        bus.acc_valid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.acc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("capture_timeout", 32'h0, 32'h1);
        cap_on_last = bus.out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_check_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (exp_q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("drain_done", {31'h0, ok}, 32'h1);
        check("idle_acc_ready", {31'h0, bus.acc_ready}, 32'h1);
        check("idle_busy", {31'h0, bus.busy}, 32'h0);
        check("idle_out_last", {31'h0, bus.out_last}, 32'h0);
    endtask

    localparam logic [63:0] TILE_A = {16'h8000, 16'h0100, 16'hFF80, 16'h0005};
    localparam logic [63:0] TILE_B = {16'hFFFF, 16'h0000, 16'hFED4, 16'h0123}; // 291,-300,0,-1

    initial begin
        logic [7:0] sat_a[]  = '{8'h05, 8'h80, 8'h7F, 8'h80};
        logic [7:0] full_a[] = '{8'h05, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80};
        logic [7:0] sat_b[]  = '{8'h12, 8'hED, 8'h00, 8'hFF};
        int base;
        bit ok;

        bus.acc_in    = '0;
        bus.acc_valid = 1'b0;
        bus.mode_sat  = 1'b0;
        bus.shift     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_acc_ready", {31'h0, bus.acc_ready}, 32'h1);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_out_last", {31'h0, bus.out_last}, 32'h0);
        check("rst_out_data", {24'h0, bus.out_data}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Case 1: saturating, no shift
        push_bytes(sat_a, 4);
        send_tile(TILE_A, 1'b1, 4'd0);
        bus.acc_valid = 1'b0;
        check("c1_latency_valid", {31'h0, bus.out_valid}, 32'h1);
        drain_and_check_idle();

        // Case 2: full width; mode/shift changes after capture must be ignored
        push_bytes(full_a, 8);
        send_tile(TILE_A, 1'b0, 4'd0);
        bus.acc_valid = 1'b0;
        bus.mode_sat  = 1'b1;
        bus.shift     = 4'd7;
        drain_and_check_idle();

        // Case 3: saturating with shift 4
        push_bytes(sat_b, 4);
        send_tile(TILE_B, 1'b1, 4'd4);
        bus.acc_valid = 1'b0;
        drain_and_check_idle();

        // Case 4: case 2 under heavy random backpressure
        stall_mode = 1'b1;
        push_bytes(full_a, 8);
        send_tile(TILE_A, 1'b0, 4'd0);
        bus.acc_valid = 1'b0;
        drain_and_check_idle();
        stall_mode = 1'b0;
        @(posedge clk);
        #1;

        // Case 5: back-to-back tiles with acc_valid held high
        push_bytes(sat_a, 4);
        send_tile(TILE_A, 1'b1, 4'd0);
        push_bytes(sat_b, 4);
        send_tile(TILE_B, 1'b1, 4'd4);
        bus.acc_valid = 1'b0;
        check("c5_capture_on_last", {31'h0, cap_on_last}, 32'h1);
        check("c5_no_bubble", {31'h0, bus.out_valid}, 32'h1);
        drain_and_check_idle();

        // Case 6: reset after two bytes of case 1
        base = pops;
        push_bytes(sat_a, 4);
        send_tile(TILE_A, 1'b1, 4'd0);
        bus.acc_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (pops >= base + 2) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("c6_two_bytes", {31'h0, ok}, 32'h1);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("c6_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("c6_rst_acc_ready", {31'h0, bus.acc_ready}, 32'h1);
        check("c6_rst_out_data", {24'h0, bus.out_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("c6_idle_after_rst", {31'h0, bus.out_valid}, 32'h0);
        push_bytes(sat_a, 4);
        send_tile(TILE_A, 1'b1, 4'd0);
        bus.acc_valid = 1'b0;
        drain_and_check_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
